i_fetch_q: RTL and testbench
============================

Name: i_fetch_q

Overview:
Parametrised instruction-fetch stage with a prefetch queue. It drives a PC into the combinational instruction memory every cycle. Fetched {instruction, PC+4} pairs are buffered in a DEPTH-entry FIFO, so fetch continues while decode is stalled. It sits between the instruction memory and the decode stage, and replaces the single-register fetch stage. Adds reset PC, redirect flush, valid/stall handshake, occupancy reporting and NOP substitution when empty.

Parameters:
WIDTH, 32, instruction and address width in bits
DEPTH, 4, prefetch queue entries; power of two, >= 2
RESET_PC, 0, PC value loaded on reset
PC_STEP, 4, bytes added to PC per sequential fetch
NOP_INSTR, 0, value driven on out_instr when the queue is empty

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
imem_addr  output  WIDTH  current fetch PC, combinational from the PC register
imem_instr  input  WIDTH  instruction at imem_addr, valid in the same cycle
redirect  input  1  taken branch/jump: flush the queue and load target
target  input  WIDTH  redirect PC
stall  input  1  decode cannot accept this cycle (OR of all lock sources)
out_valid  output  1  queue head holds a valid instruction
out_instr  output  WIDTH  head instruction, or NOP_INSTR when empty
out_pc_plus_four  output  WIDTH  PC+PC_STEP of the head entry, 0 when empty
occupancy  output  clog2(DEPTH+1)  number of valid entries
fetch_pc  output  WIDTH  copy of the PC register

Behaviour:
- Reset (sampled at posedge clk while reset=1):
  - pc=RESET_PC; rd_ptr=wr_ptr=0; count=0.
  - Outputs: out_valid=0, out_instr=NOP_INSTR, out_pc_plus_four=0, occupancy=0.
  - Reset overrides redirect and every other input.
- Pop:
  - pop = out_valid & ~stall.
  - A pop advances rd_ptr mod DEPTH at the edge.
  - Consumer samples out_instr and out_pc_plus_four in the cycle pop=1.
- Push:
  - push = ~redirect & (count<DEPTH | pop).
  - On push: entry[wr_ptr] <= {imem_instr, pc+PC_STEP}; wr_ptr advances mod DEPTH; pc <= pc+PC_STEP.
  - Full and popping in the same cycle: push is allowed, count is unchanged.
  - Full and not popping: no push, and pc holds.
- Count update:
  - count += push - pop.
  - It never exceeds DEPTH and never underflows; pop requires count>0.
- Redirect (reset=0, redirect=1):
  - pc <= target; rd_ptr=wr_ptr=0; count=0; no push that cycle.
  - A pop in the same cycle still counts as accepted by the consumer. All other entries are discarded.
  - Next cycle: imem_addr=target and out_valid=0.
  - The first instruction from target appears at out_valid one cycle after that, i.e. two cycles after redirect.
- Latency: sequential fetch into an empty queue shows the instruction at out_valid one cycle after imem_addr presents its PC.
- Output path:
  - out_valid = (count!=0).
  - Outputs are read from registered queue storage, with no combinational path from imem_instr.
  - The empty case drives NOP_INSTR and 0.
- Arithmetic:
  - pc+PC_STEP wraps mod 2^WIDTH; no overflow flag.
  - Pointers are clog2(DEPTH) bits and wrap naturally.
- Stall:
  - stall=1 never changes the head or its outputs.
  - Fetch continues until the queue is full, then pc freezes at the address of the next unfetched instruction.
- X handling: entries are not reset. Outputs must never expose a stale entry while count=0.

Test Plan:
- Reset with RESET_PC=0x100 and stall=0, imem word at 0x100+4k returning 0xA000_0000+k -> imem_addr 0x100,0x104,0x108 on successive cycles; out_instr 0xA000_0000,0xA000_0001,… one cycle behind, with out_pc_plus_four 0x104,0x108,….
- Hold stall=1 for 10 cycles from reset, DEPTH=4 -> occupancy ramps 1,2,3,4 and then holds; imem_addr freezes at RESET_PC+16; out_instr stays at the first word. Release stall -> four pops in order, no duplicates, no gaps.
- Queue full, assert stall=0 and keep fetching -> occupancy stays 4 each cycle (simultaneous push and pop); PC advances by 4 every cycle.
- redirect=1 with target=0x2000 while occupancy=3 -> next cycle occupancy=0, out_valid=0, out_instr=NOP_INSTR, imem_addr=0x2000. Following cycle out_pc_plus_four=0x2004.
- RESET_PC=0xFFFF_FFF8 -> imem_addr sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 (wrap); out_pc_plus_four 0xFFFF_FFFC, 0x0000_0000, 0x0000_0004.
- Assert reset mid-stream with occupancy=2 and redirect=1 in the same cycle -> next cycle occupancy=0, imem_addr=RESET_PC (not target), out_valid=0.

Source files
------------

// File: rtl/i_fetch_q_if.sv
// rtl/i_fetch_q_if.sv - fetch-stage bundle: imem port, redirect/stall control, queue head outputs
interface i_fetch_q_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    logic [WIDTH-1:0]           imem_addr;
    logic [WIDTH-1:0]           imem_instr;
    logic                       redirect;
    logic [WIDTH-1:0]           target;
    logic                       stall;
    logic                       out_valid;
    logic [WIDTH-1:0]           out_instr;
    logic [WIDTH-1:0]           out_pc_plus_four;
    logic [$clog2(DEPTH+1)-1:0] occupancy;
    logic [WIDTH-1:0]           fetch_pc;

    modport slave (
        output imem_addr, out_valid, out_instr, out_pc_plus_four, occupancy, fetch_pc,
        input  imem_instr, redirect, target, stall
    );

    modport master (
        input  imem_addr, out_valid, out_instr, out_pc_plus_four, occupancy, fetch_pc,
        output imem_instr, redirect, target, stall
    );
endinterface

// File: rtl/i_fetch_q.sv
// rtl/i_fetch_q.sv - instruction fetch stage with a DEPTH-entry prefetch queue
module i_fetch_q #(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter logic [WIDTH-1:0] PC_STEP   = WIDTH'(4),
    parameter logic [WIDTH-1:0] NOP_INSTR = '0
) (
    input  logic       clk,
    input  logic       reset,
    i_fetch_q_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    // Queue storage is deliberately not reset; out_valid gates every read.
    logic [WIDTH-1:0] instr_q [DEPTH];
    logic [WIDTH-1:0] ppf_q   [DEPTH];

    logic             valid;
    logic             pop;
    logic             push;
    logic [WIDTH-1:0] pc_next_seq;

    always_comb begin
        valid       = (count_q != '0);
        pop         = valid & ~bus.stall;
        push        = ~bus.redirect & ((count_q != DEPTH_C) | pop);
        pc_next_seq = pc_q + PC_STEP;

        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (bus.redirect) begin
            // A head popped this cycle is still taken by decode; everything else is dropped.
            pc_d     = bus.target;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
                pc_d     = pc_next_seq;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            instr_q[wr_ptr_q] <= bus.imem_instr;
            ppf_q[wr_ptr_q]   <= pc_next_seq;
        end
    end

    always_comb begin
        bus.imem_addr        = pc_q;
        bus.fetch_pc         = pc_q;
        bus.occupancy        = count_q;
        bus.out_valid        = valid;
        bus.out_instr        = valid ? instr_q[rd_ptr_q] : NOP_INSTR;
        bus.out_pc_plus_four = valid ? ppf_q[rd_ptr_q] : '0;
    end
endmodule

// File: tb/tb_i_fetch_q.sv
// tb/tb_i_fetch_q.sv - directed self-checking bench for i_fetch_q
module tb_i_fetch_q;
    logic clk = 1'b0;
    logic reset_a = 1'b1;
    logic reset_b = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    i_fetch_q_if #(.WIDTH(32), .DEPTH(4)) bus_a ();
    i_fetch_q_if #(.WIDTH(32), .DEPTH(4)) bus_b ();

    // imem word at base+4k returns 0xA000_0000+k
    assign bus_a.imem_instr = 32'hA000_0000 + ((bus_a.imem_addr - 32'h0000_0100) >> 2);
    assign bus_b.imem_instr = 32'hA000_0000 + ((bus_b.imem_addr - 32'hFFFF_FFF8) >> 2);

    i_fetch_q #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'h0000_0100), .PC_STEP(32'd4), .NOP_INSTR(32'h0))
        dut_a (.clk(clk), .reset(reset_a), .bus(bus_a));

    i_fetch_q #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8), .PC_STEP(32'd4), .NOP_INSTR(32'h0))
        dut_b (.clk(clk), .reset(reset_b), .bus(bus_b));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_a = 1'b1;
        tick();
        tick();
        checks++;
        if (bus_a.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got=%0b exp=0", bus_a.out_valid);
        end
        checks++;
        if (bus_a.out_instr !== 32'h0) begin
            failures++;
            $display("FAIL reset_instr got=%h exp=00000000", bus_a.out_instr);
        end
        checks++;
        if (bus_a.out_pc_plus_four !== 32'h0) begin
            failures++;
            $display("FAIL reset_ppf got=%h exp=00000000", bus_a.out_pc_plus_four);
        end
        checks++;
        if (bus_a.occupancy !== 3'd0) begin
            failures++;
            $display("FAIL reset_occ got=%0d exp=0", bus_a.occupancy);
        end
        checks++;
        if (bus_a.imem_addr !== 32'h100 || bus_a.fetch_pc !== 32'h100) begin
            failures++;
            $display("FAIL reset_pc got=%h/%h exp=00000100", bus_a.imem_addr, bus_a.fetch_pc);
        end
        reset_a = 1'b0;
    endtask

    task automatic test_seq_fetch();
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (bus_a.imem_addr !== 32'h100 + 32'(4 * (k + 1))) begin
                failures++;
                $display("FAIL seq_addr[%0d] got=%h exp=%h", k, bus_a.imem_addr, 32'h100 + 32'(4 * (k + 1)));
            end
            checks++;
            if (bus_a.out_valid !== 1'b1 || bus_a.out_instr !== 32'hA000_0000 + 32'(k)) begin
                failures++;
                $display("FAIL seq_instr[%0d] got=%b/%h exp=1/%h", k, bus_a.out_valid, bus_a.out_instr, 32'hA000_0000 + 32'(k));
            end
            checks++;
            if (bus_a.out_pc_plus_four !== 32'h104 + 32'(4 * k) || bus_a.occupancy !== 3'd1) begin
                failures++;
                $display("FAIL seq_ppf[%0d] got=%h occ=%0d exp=%h occ=1", k, bus_a.out_pc_plus_four, bus_a.occupancy, 32'h104 + 32'(4 * k));
            end
        end
    endtask

    task automatic test_stall_fill();
        int n;
        reset_a = 1'b1;
        bus_a.stall = 1'b1;
        tick();
        reset_a = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            n = (i < 4) ? i : 4;
            checks++;
            if (bus_a.occupancy !== 3'(n) || bus_a.imem_addr !== 32'h100 + 32'(4 * n)) begin
                failures++;
                $display("FAIL stall_fill[%0d] got occ=%0d addr=%h exp occ=%0d addr=%h", i, bus_a.occupancy, bus_a.imem_addr, n, 32'h100 + 32'(4 * n));
            end
            checks++;
            if (bus_a.out_instr !== 32'hA000_0000 || bus_a.out_pc_plus_four !== 32'h104) begin
                failures++;
                $display("FAIL stall_head[%0d] got=%h/%h exp=a0000000/00000104", i, bus_a.out_instr, bus_a.out_pc_plus_four);
            end
        end
    endtask

    task automatic test_back_to_back();
        bus_a.stall = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (bus_a.out_instr !== 32'hA000_0000 + 32'(k) || bus_a.out_pc_plus_four !== 32'h104 + 32'(4 * k)) begin
                failures++;
                $display("FAIL b2b_head[%0d] got=%h/%h exp=%h/%h", k, bus_a.out_instr, bus_a.out_pc_plus_four, 32'hA000_0000 + 32'(k), 32'h104 + 32'(4 * k));
            end
            checks++;
            if (bus_a.occupancy !== 3'd4 || bus_a.imem_addr !== 32'h110 + 32'(4 * k)) begin
                failures++;
                $display("FAIL b2b_occ[%0d] got occ=%0d addr=%h exp occ=4 addr=%h", k, bus_a.occupancy, bus_a.imem_addr, 32'h110 + 32'(4 * k));
            end
            tick();
        end
    endtask

    task automatic test_redirect();
        reset_a = 1'b1;
        bus_a.stall = 1'b1;
        tick();
        reset_a = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (bus_a.occupancy !== 3'd3) begin
            failures++;
            $display("FAIL redir_pre_occ got=%0d exp=3", bus_a.occupancy);
        end
        bus_a.redirect = 1'b1;
        bus_a.target = 32'h2000;
        tick();
        bus_a.redirect = 1'b0;
        checks++;
        if (bus_a.occupancy !== 3'd0 || bus_a.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL redir_flush got occ=%0d valid=%b exp occ=0 valid=0", bus_a.occupancy, bus_a.out_valid);
        end
        checks++;
        if (bus_a.out_instr !== 32'h0 || bus_a.out_pc_plus_four !== 32'h0 || bus_a.imem_addr !== 32'h2000) begin
            failures++;
            $display("FAIL redir_outs got=%h/%h addr=%h exp=00000000/00000000 addr=00002000", bus_a.out_instr, bus_a.out_pc_plus_four, bus_a.imem_addr);
        end
        tick();
        checks++;
        if (bus_a.out_valid !== 1'b1 || bus_a.out_pc_plus_four !== 32'h2004 || bus_a.out_instr !== 32'hA000_07C0) begin
            failures++;
            $display("FAIL redir_first got=%b/%h/%h exp=1/00002004/a00007c0", bus_a.out_valid, bus_a.out_pc_plus_four, bus_a.out_instr);
        end
    endtask

    task automatic test_reset_mid();
        tick();
        checks++;
        if (bus_a.occupancy !== 3'd2) begin
            failures++;
            $display("FAIL rmid_pre_occ got=%0d exp=2", bus_a.occupancy);
        end
        reset_a = 1'b1;
        bus_a.redirect = 1'b1;
        bus_a.target = 32'h3000;
        tick();
        reset_a = 1'b0;
        bus_a.redirect = 1'b0;
        checks++;
        if (bus_a.occupancy !== 3'd0 || bus_a.out_valid !== 1'b0 || bus_a.imem_addr !== 32'h100) begin
            failures++;
            $display("FAIL rmid got occ=%0d valid=%b addr=%h exp occ=0 valid=0 addr=00000100", bus_a.occupancy, bus_a.out_valid, bus_a.imem_addr);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_addr [4];
        logic [31:0] exp_ppf  [3];
        exp_addr[0] = 32'hFFFF_FFF8;
        exp_addr[1] = 32'hFFFF_FFFC;
        exp_addr[2] = 32'h0000_0000;
        exp_addr[3] = 32'h0000_0004;
        exp_ppf[0]  = 32'hFFFF_FFFC;
        exp_ppf[1]  = 32'h0000_0000;
        exp_ppf[2]  = 32'h0000_0004;
        reset_b = 1'b1;
        tick();
        reset_b = 1'b0;
        checks++;
        if (bus_b.imem_addr !== exp_addr[0]) begin
            failures++;
            $display("FAIL wrap_addr[0] got=%h exp=%h", bus_b.imem_addr, exp_addr[0]);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (bus_b.imem_addr !== exp_addr[k+1]) begin
                failures++;
                $display("FAIL wrap_addr[%0d] got=%h exp=%h", k + 1, bus_b.imem_addr, exp_addr[k+1]);
            end
            checks++;
            if (bus_b.out_pc_plus_four !== exp_ppf[k] || bus_b.out_instr !== 32'hA000_0000 + 32'(k)) begin
                failures++;
                $display("FAIL wrap_head[%0d] got=%h/%h exp=%h/%h", k, bus_b.out_pc_plus_four, bus_b.out_instr, exp_ppf[k], 32'hA000_0000 + 32'(k));
            end
        end
    endtask

    initial begin
        bus_a.stall = 1'b0;
        bus_a.redirect = 1'b0;
        bus_a.target = 32'h0;
        bus_b.stall = 1'b0;
        bus_b.redirect = 1'b0;
        bus_b.target = 32'h0;
        test_reset();
        test_seq_fetch();
        test_stall_fill();
        test_back_to_back();
        test_redirect();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
